// File: rtl/tile_pkg.sv
// Shared definitions for the systolic array tile: phase encodings and default widths.
package tile_pkg;

    localparam int DW    = 8;
    localparam int ROW_W = 4;
    localparam int COL_W = 4;

    // Array-wide phase code broadcast to every PE
    typedef enum logic [1:0] {
        ST_LOAD_W = 2'd0,
        ST_LOAD_X = 2'd1,
        ST_MAC    = 2'd2,
        ST_IDLE   = 2'd3
    } phase_e;

endpackage

// File: rtl/pe_mac.sv
// Combinational unsigned multiply-add: y = a*b + c, truncated to 2*DW bits (wraps).
module pe_mac #(
    parameter int DW = 8
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [2*DW-1:0] c,
    output logic [2*DW-1:0] y
);

    logic [2*DW-1:0] prod;

    // Full-width product, then a modular add back into the same width
    always_comb begin
        prod = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        y    = prod + c;
    end

endmodule

// File: rtl/tile_pe.sv
// Weight-stationary MAC processing element for a 2-D systolic tile.
// Holds a weight captured from the broadcast config bus, forwards the
// activation east and passes acc_in + w*x south, all registered.
module tile_pe
    import tile_pkg::*;
#(
    parameter int DW     = tile_pkg::DW,
    parameter int ROW_W  = tile_pkg::ROW_W,
    parameter int COL_W  = tile_pkg::COL_W,
    parameter int ADDR_W = ROW_W + COL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROW_W-1:0]  core_row,
    input  logic [COL_W-1:0]  core_col,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DW-1:0]     cfg_data,
    input  logic              cfg_valid,
    input  logic [1:0]        global_state,
    input  logic [DW-1:0]     x_in,
    input  logic [2*DW-1:0]   acc_in,
    output logic [DW-1:0]     x_reg_out,
    output logic [2*DW-1:0]   acc_reg_out
);

    phase_e          phase;
    logic            addr_hit;
    logic [2*DW-1:0] mac_y;

    logic [DW-1:0]   w_d,   w_q;
    logic [DW-1:0]   x_d,   x_q;
    logic [2*DW-1:0] acc_d, acc_q;

    // Phase is used as sampled at the edge; row occupies the address MSBs
    assign phase    = phase_e'(global_state);
    assign addr_hit = (cfg_addr == {core_row, core_col});

    pe_mac #(.DW(DW)) u_mac (
        .a (w_q),
        .b (x_q),
        .c (acc_in),
        .y (mac_y)
    );

    // Next-state selection per phase; anything not named holds
    always_comb begin
        w_d   = w_q;
        x_d   = x_q;
        acc_d = acc_q;
        case (phase)
            ST_LOAD_W: if (cfg_valid && addr_hit) w_d = cfg_data;
            ST_LOAD_X: x_d = x_in;
            ST_MAC: begin
                acc_d = mac_y;   // uses x_q before it advances below
                x_d   = x_in;
            end
            default: ;
        endcase
    end

    // Datapath registers, cleared immediately on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= '0;
            x_q   <= '0;
            acc_q <= '0;
        end else begin
            w_q   <= w_d;
            x_q   <= x_d;
            acc_q <= acc_d;
        end
    end

    assign x_reg_out   = x_q;
    assign acc_reg_out = acc_q;

endmodule

// File: tb/tb_tile_pe.sv
// Self-checking bench for tile_pe: directed scenarios plus a randomized run
// against a behavioural model of the PE's weight/activation/partial-sum state.
module tb_tile_pe;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  core_row = 4'd1;
    logic [3:0]  core_col = 4'd2;
    logic [7:0]  cfg_addr = '0;
    logic [7:0]  cfg_data = '0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  global_state = 2'd3;
    logic [7:0]  x_in = '0;
    logic [15:0] acc_in = '0;
    logic [7:0]  x_reg_out;
    logic [15:0] acc_reg_out;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model state
    int m_w, m_x, m_acc;

    tile_pe #(.DW(8), .ROW_W(4), .COL_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .core_row     (core_row),
        .core_col     (core_col),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .global_state (global_state),
        .x_in         (x_in),
        .acc_in       (acc_in),
        .x_reg_out    (x_reg_out),
        .acc_reg_out  (acc_reg_out)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model advances by the phase rules, sampled #1 after the edge
    task automatic step(input int st, input int addr, input int data, input bit vld,
                        input int xi, input int ai);
        @(negedge clk);
        global_state = st[1:0];
        cfg_addr     = addr[7:0];
        cfg_data     = data[7:0];
        cfg_valid    = vld;
        x_in         = xi[7:0];
        acc_in       = ai[15:0];
        @(posedge clk);
        if (st == 0) begin
            if (vld && addr == core_row * 16 + core_col) m_w = data;
        end else if (st == 1) begin
            m_x = xi;
        end else if (st == 2) begin
            m_acc = (ai + m_w * m_x) % 65536;
            m_x   = xi;
        end
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        cfg_valid = 1'b0;
        global_state = 2'd3;
        #2;
        m_w = 0; m_x = 0; m_acc = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if (x_reg_out !== 8'd0) begin
            n_err++; $display("FAIL reset_x: got %0d want 0", x_reg_out);
        end
        n_vec++;
        if (acc_reg_out !== 16'd0) begin
            n_err++; $display("FAIL reset_acc: got %0d want 0", acc_reg_out);
        end
    endtask

    task automatic test_basic_mac();
        apply_reset();
        step(0, 8'h12, 5, 1, 0, 0);
        step(1, 0, 0, 0, 3, 0);
        n_vec++;
        if (x_reg_out !== 8'd3) begin
            n_err++; $display("FAIL basic_xload: got %0d want 3", x_reg_out);
        end
        step(2, 0, 0, 0, 0, 10);
        n_vec++;
        if (acc_reg_out !== 16'd25) begin
            n_err++; $display("FAIL basic_mac: got %0d want 25", acc_reg_out);
        end
    endtask

    task automatic test_addr_mismatch();
        apply_reset();
        step(0, 8'h21, 7, 1, 0, 0);
        step(1, 0, 0, 0, 3, 0);
        step(2, 0, 0, 0, 0, 0);
        n_vec++;
        if (acc_reg_out !== 16'd0) begin
            n_err++; $display("FAIL addr_mismatch: got %0d want 0", acc_reg_out);
        end
    endtask

    task automatic test_cfg_outside_load_w();
        apply_reset();
        step(0, 8'h12, 5, 1, 0, 0);
        step(1, 8'h12, 9, 1, 2, 0);
        step(3, 8'h12, 9, 1, 0, 0);
        step(2, 8'h12, 9, 1, 0, 1);
        n_vec++;
        if (acc_reg_out !== 16'd11) begin
            n_err++; $display("FAIL cfg_ignored: got %0d want 11", acc_reg_out);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        step(0, 8'h12, 255, 1, 0, 0);
        step(1, 0, 0, 0, 255, 0);
        step(2, 0, 0, 0, 0, 16'hFFFF);
        n_vec++;
        if (acc_reg_out !== 16'hFE00) begin
            n_err++; $display("FAIL wrap: got %h want fe00", acc_reg_out);
        end
    endtask

    task automatic test_streaming();
        int xs[3]   = '{4, 6, 8};
        int accs[3] = '{2, 8, 12};
        apply_reset();
        step(0, 8'h12, 2, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(2, 0, 0, 0, xs[i], 0);
            n_vec++;
            if (acc_reg_out !== 16'(accs[i])) begin
                n_err++; $display("FAIL stream_acc[%0d]: got %0d want %0d", i, acc_reg_out, accs[i]);
            end
            n_vec++;
            if (x_reg_out !== 8'(xs[i])) begin
                n_err++; $display("FAIL stream_x[%0d]: got %0d want %0d", i, x_reg_out, xs[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        // streaming leaves acc=12, x=8, w=2
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (acc_reg_out !== 16'd0) begin
            n_err++; $display("FAIL async_rst_acc: got %0d want 0", acc_reg_out);
        end
        n_vec++;
        if (x_reg_out !== 8'd0) begin
            n_err++; $display("FAIL async_rst_x: got %0d want 0", x_reg_out);
        end
        #1;
        rst_n = 1'b1;
        m_w = 0; m_x = 0; m_acc = 0;
        step(1, 0, 0, 0, 7, 0);
        step(2, 0, 0, 0, 0, 37);
        n_vec++;
        if (acc_reg_out !== 16'd37) begin
            n_err++; $display("FAIL post_rst_mac: got %0d want 37", acc_reg_out);
        end
    endtask

    task automatic test_random();
        int st, addr, data, xi, ai;
        bit vld;
        apply_reset();
        core_row = 4'($urandom_range(0, 15));
        core_col = 4'($urandom_range(0, 15));
        for (int i = 0; i < 300; i++) begin
            st   = $urandom_range(0, 3);
            vld  = 1'($urandom_range(0, 1));
            addr = ($urandom_range(0, 1) == 1) ? core_row * 16 + core_col : $urandom_range(0, 255);
            data = $urandom_range(0, 255);
            xi   = $urandom_range(0, 255);
            ai   = $urandom_range(0, 65535);
            step(st, addr, data, vld, xi, ai);
            n_vec++;
            if (x_reg_out !== 8'(m_x)) begin
                n_err++; $display("FAIL rand_x[%0d]: got %0d want %0d", i, x_reg_out, m_x);
            end
            n_vec++;
            if (acc_reg_out !== 16'(m_acc)) begin
                n_err++; $display("FAIL rand_acc[%0d]: got %0d want %0d", i, acc_reg_out, m_acc);
            end
        end
    endtask

    initial begin
        m_w = 0; m_x = 0; m_acc = 0;
        test_reset();
        test_basic_mac();
        test_addr_mismatch();
        test_cfg_outside_load_w();
        test_wrap();
        test_streaming();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tile_pe.md
# tile_pe

Weight-stationary multiply-accumulate processing element for a 2-D systolic array tile. Each instance is identified by a (row, column) coordinate and captures its weight from a broadcast configuration bus. It registers an activation that is forwarded to its neighbour and adds weight × activation to a partial sum arriving from upstream. A global phase code shared by all PEs in the array sequences it.

## Interface
Parameters:
- DW, 8, data width of weight and activation; accumulator is 2*DW
- ROW_W, 4, width of row coordinate
- COL_W, 4, width of column coordinate
- ADDR_W, ROW_W+COL_W, width of configuration address (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- core_row  in  ROW_W  this PE's row coordinate (static)
- core_col  in  COL_W  this PE's column coordinate (static)
- cfg_addr  in  ADDR_W  configuration target {row, col}
- cfg_data  in  DW  weight value to load
- cfg_valid  in  1  configuration write strobe
- global_state  in  2  array phase: 0 LOAD_W, 1 LOAD_X, 2 MAC, 3 IDLE
- x_in  in  DW  activation from west neighbour / input feeder
- acc_in  in  2*DW  partial sum from north neighbour
- x_reg_out  out  DW  registered activation, to east neighbour
- acc_reg_out  out  2*DW  registered partial sum, to south neighbour

## Operation
- Internal registers: w_reg (DW), x_reg (DW), acc_reg (2*DW). x_reg_out = x_reg; acc_reg_out = acc_reg.
- All arithmetic is unsigned.
- LOAD_W (0): w_reg <= cfg_data when cfg_valid=1 and cfg_addr == {core_row, core_col}, with row in the MSBs. Otherwise w_reg holds. x_reg and acc_reg hold.
- LOAD_X (1): x_reg <= x_in. w_reg and acc_reg hold.
- MAC (2): acc_reg <= acc_in + w_reg * x_reg, using the pre-edge value of x_reg. The product is a full 2*DW bits. The sum is truncated to 2*DW bits, wrapping mod 2^(2*DW). In the same edge, x_reg <= x_in, which forwards the activation systolically. w_reg holds.
- IDLE (3): all registers hold.
- cfg_valid is ignored outside LOAD_W, even when the address matches.
- The global_state value is not registered locally. The PE acts on the value sampled at each rising edge.

## Timing
- Reset (rst_n low, asynchronous): w_reg, x_reg and acc_reg clear to 0 immediately. Both outputs read 0.
- Weight load latency: 1 cycle. The new w_reg is visible to a MAC in the next cycle.
- Activation load: 1 cycle to x_reg_out.
- MAC latency: 1 cycle from acc_in to acc_reg_out. There is no combinational path from any input to any output.
- Back-to-back cycles are supported: LOAD_W → LOAD_X → MAC on consecutive edges yields the correct result on the edge after MAC.
- Consecutive MAC cycles: each edge computes with the x_reg value loaded by the prior edge, then advances x_reg.
- Reset asserted mid-operation aborts immediately. After release, registers restart from 0 and require a fresh weight load.

## Structure
- Shared package (tile_pkg): state encodings ST_LOAD_W=2'd0, ST_LOAD_X=2'd1, ST_MAC=2'd2, ST_IDLE=2'd3. Default widths DW/ROW_W/COL_W also live there for array-level reuse.
- One natural sub-module: pe_mac, a combinational unsigned a*b + c with 2*DW truncation, instantiated once.
- Address match and state decode are inline in tile_pe.

## Test plan
- Basic MAC: core=(1,2); LOAD_W with cfg_addr=0x12, cfg_data=5; LOAD_X x_in=3; MAC acc_in=10 → acc_reg_out=25 one cycle after the MAC edge. x_reg_out=3 after LOAD_X.
- Address mismatch: core=(1,2); LOAD_W cfg_addr=0x21, cfg_data=7; then x=3, acc_in=0 MAC → acc_reg_out=0 (weight stays 0).
- cfg_valid outside LOAD_W: with weight=5, assert cfg_valid, addr match, data=9 while state=LOAD_X → weight still 5; MAC x=2, acc_in=1 → 11.
- Wrap-around: weight=255, x=255, acc_in=0xFFFF, MAC → acc_reg_out=0xFE00, i.e. (0xFE01+0xFFFF) mod 2^16.
- Systolic streaming: weight=2, x_reg=1; MAC for 3 cycles with x_in=4,6,8 and acc_in=0 → acc_reg_out sequence 2,8,12. x_reg_out sequence 4,6,8.
- Async reset mid-run: after a nonzero MAC result, pulse rst_n low between clock edges → both outputs 0 before the next edge. A later MAC without reloading the weight gives acc_reg_out=acc_in.
